// File: rtl/keypad_scanner_param.sv
// Row-scanning matrix keypad front end: debounced press/release detection,
// multi-key rejection and optional auto-repeat, reporting a linear key index.
//
// state    | meaning
// IDLE     | scanning disabled, all rows released
// SETTLE   | current row driven low, waiting for the columns to settle
// DEBOUNCE | single closure seen, confirming it stays stable
// HELD     | key accepted, waiting for all columns to open
// RELEASE  | columns open, confirming the release is stable
module keypad_scanner_param #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 25,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000,
    localparam int KW             = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_en,
    input  logic [COLS-1:0] col_matrix,
    output logic [ROWS-1:0] lin_matrix,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_repeat,
    output logic            key_held,
    output logic            key_release
);

    localparam int RW       = $clog2(ROWS);
    localparam int CIW      = $clog2(COLS);
    localparam int CNT_MAX  = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNTW     = $clog2(CNT_MAX + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   row_q;
    logic [RW-1:0]   next_row;
    logic [CNTW-1:0] cnt_q;
    logic [HW-1:0]   hold_q;
    logic [CIW-1:0]  col_q;
    logic [COLS-1:0] pat_q;

    logic [COLS-1:0] col_low;
    logic            any_low;
    logic            one_low;
    logic [CIW-1:0]  col_idx;
    logic [CIW-1:0]  acc_col;
    logic            accept;
    logic            rel_done;

    function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
        row_drive = ~(ROWS'(1) << r);
    endfunction

    function automatic logic [KW-1:0] code_of(input logic [RW-1:0] r, input logic [CIW-1:0] c);
        code_of = KW'(int'(r) * COLS + int'(c));
    endfunction

    always_comb begin
        col_low = ~col_matrix;
        any_low = |col_low;
        one_low = any_low && ((col_low & (col_low - COLS'(1))) == '0);
        col_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (col_low[i]) begin
                col_idx = CIW'(i);
            end
        end
        next_row = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        acc_col  = (state_q == SETTLE) ? col_idx : col_q;
    end

    // A single debounce cycle means the settle sample itself is the acceptance.
    always_comb begin
        accept = scan_en &&
                 ((state_q == SETTLE && cnt_q == CNTW'(SETTLE_CYCLES) && one_low &&
                   DEBOUNCE_CYCLES == 1) ||
                  (state_q == DEBOUNCE && col_matrix == pat_q &&
                   cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)));
        rel_done = !any_low &&
                   ((state_q == HELD && DEBOUNCE_CYCLES == 1) ||
                    (state_q == RELEASE && cnt_q == CNTW'(DEBOUNCE_CYCLES - 1)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            col_q       <= '0;
            pat_q       <= '1;
            lin_matrix  <= '1;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_repeat  <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_repeat  <= 1'b0;
            key_release <= 1'b0;
            case (state_q)
                IDLE: begin
                    lin_matrix <= '1;
                    cnt_q      <= '0;
                    if (scan_en) begin
                        state_q    <= SETTLE;
                        cnt_q      <= CNTW'(1);
                        lin_matrix <= row_drive(row_q);
                    end
                end
                SETTLE: begin
                    if (!scan_en) begin
                        state_q    <= IDLE;
                        lin_matrix <= '1;
                        cnt_q      <= '0;
                    end else if (cnt_q == CNTW'(SETTLE_CYCLES)) begin
                        if (one_low) begin
                            pat_q   <= col_matrix;
                            col_q   <= col_idx;
                            state_q <= DEBOUNCE;
                            cnt_q   <= CNTW'(1);
                        end else begin
                            row_q      <= next_row;
                            lin_matrix <= row_drive(next_row);
                            cnt_q      <= CNTW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!scan_en) begin
                        state_q    <= IDLE;
                        lin_matrix <= '1;
                        cnt_q      <= '0;
                    end else if (col_matrix != pat_q) begin
                        state_q    <= SETTLE;
                        row_q      <= next_row;
                        lin_matrix <= row_drive(next_row);
                        cnt_q      <= CNTW'(1);
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                HELD: begin
                    if (!any_low) begin
                        state_q <= RELEASE;
                        cnt_q   <= CNTW'(1);
                    end else if (REPEAT_EN != 0) begin
                        // Hold timer survives release bounces; it only advances while closed.
                        if (hold_q == HW'(1)) begin
                            key_valid  <= 1'b1;
                            key_repeat <= 1'b1;
                            hold_q     <= HW'(REPEAT_PERIOD);
                        end else if (hold_q != '0) begin
                            hold_q <= hold_q - HW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (any_low) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    lin_matrix <= '1;
                    cnt_q      <= '0;
                end
            endcase

            if (accept) begin
                key_valid <= 1'b1;
                key_code  <= code_of(row_q, acc_col);
                key_held  <= 1'b1;
                hold_q    <= HW'(REPEAT_DELAY);
                state_q   <= HELD;
                cnt_q     <= '0;
            end

            if (rel_done) begin
                key_release <= 1'b1;
                key_held    <= 1'b0;
                row_q       <= next_row;
                if (scan_en) begin
                    state_q    <= SETTLE;
                    lin_matrix <= row_drive(next_row);
                    cnt_q      <= CNTW'(1);
                end else begin
                    state_q    <= IDLE;
                    lin_matrix <= '1;
                    cnt_q      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Bench for keypad_scanner_param: a keypad model answers the row drive, and
// expected events come from press/hold/release timing rules.
module tb_keypad_scanner_param;

    localparam int ROWS          = 4;
    localparam int COLS          = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int DEBOUNCE      = 4;
    localparam int REPEAT_DELAY  = 20;
    localparam int REPEAT_PERIOD = 8;
    localparam int KW            = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            scan_en;
    logic [COLS-1:0] col_matrix;
    logic [ROWS-1:0] lin_matrix;
    logic [KW-1:0]   key_code;
    logic            key_valid;
    logic            key_repeat;
    logic            key_held;
    logic            key_release;

    logic [ROWS*COLS-1:0] pressed;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          v_cyc[$];
    logic [KW-1:0] v_code[$];
    logic        v_rep[$];
    int          r_cyc[$];
    int          last_sample[ROWS];
    int          run = 0;
    logic [ROWS-1:0] prev_lin;

    keypad_scanner_param #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE_CYCLES),
        .DEBOUNCE_CYCLES(DEBOUNCE), .REPEAT_EN(1),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_en(scan_en),
        .col_matrix(col_matrix),
        .lin_matrix(lin_matrix),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_repeat(key_repeat),
        .key_held(key_held),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Switch matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        col_matrix = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!lin_matrix[r] && pressed[r*COLS+c]) begin
                    col_matrix[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("valid_release_excl", 32'(key_valid && key_release), 0);
            chk("repeat_qualifier", 32'(key_repeat && !key_valid), 0);
            if (key_valid) begin
                v_cyc.push_back(cyc);
                v_code.push_back(key_code);
                v_rep.push_back(key_repeat);
            end
            if (key_release) begin
                r_cyc.push_back(cyc);
            end
        end
        if (lin_matrix == prev_lin && lin_matrix != '1) run++;
        else run = 1;
        prev_lin = lin_matrix;
        if (run == SETTLE_CYCLES) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!lin_matrix[r]) last_sample[r] = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        v_cyc.delete();
        v_code.delete();
        v_rep.delete();
        r_cyc.delete();
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!got) begin
                tick(1);
                if (v_cyc.size() > 0) got = 1'b1;
            end
        end
    endtask

    // Close one key, hold it `hold` cycles past acceptance, open it, and
    // compare press, repeat and release events with the timing rules.
    task automatic press_and_check(input int key, input int hold);
        bit got;
        int p, x, k;
        int exp_rep[$];
        clear_log();
        pressed[key] = 1'b1;
        wait_valid(300, got);
        chk("press_seen", 32'(got), 1);
        if (got) begin
            p = v_cyc[0];
            chk("press_code", 32'(v_code[0]), key);
            chk("press_repeat", 32'(v_rep[0]), 0);
            chk("press_latency", p, last_sample[key / COLS] + DEBOUNCE);
            chk("held_on", 32'(key_held), 1);
            tick(hold - 1);
            pressed[key] = 1'b0;
            x = cyc;
            tick(DEBOUNCE + 3);
            k = REPEAT_DELAY;
            while (k <= hold) begin
                exp_rep.push_back(p + k);
                k += REPEAT_PERIOD;
            end
            chk("valid_count", v_cyc.size(), 1 + exp_rep.size());
            for (int i = 0; i < exp_rep.size() && i + 1 < v_cyc.size(); i++) begin
                chk("repeat_cycle", v_cyc[i+1], exp_rep[i]);
                chk("repeat_code", 32'(v_code[i+1]), key);
                chk("repeat_flag", 32'(v_rep[i+1]), 1);
            end
            chk("release_count", r_cyc.size(), 1);
            if (r_cyc.size() > 0) chk("release_cycle", r_cyc[0], x + DEBOUNCE);
            chk("held_off", 32'(key_held), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit found;
        int x, rr, c1, c2;
        logic [ROWS-1:0] one_hot;
        logic [ROWS-1:0] exp_lin;

        reset   = 1'b0;
        scan_en = 1'b0;
        pressed = '0;
        one_hot = 4'b0001;
        tick(3);
        chk("rst_lin", 32'(lin_matrix), 32'hF);
        chk("rst_code", 32'(key_code), 0);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_repeat", 32'(key_repeat), 0);
        chk("rst_held", 32'(key_held), 0);
        chk("rst_release", 32'(key_release), 0);
        reset = 1'b1;

        // Scanning disabled: rows stay released and nothing is reported.
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle_lin", 32'(lin_matrix), 32'hF);
        end
        chk("idle_no_valid", v_cyc.size(), 0);
        chk("idle_no_release", r_cyc.size(), 0);

        // Clean press of key 9 (row 2, col 1) held long enough for four repeats.
        scan_en = 1'b1;
        press_and_check(9, 50);

        // Bouncing key 3, then stable.
        clear_log();
        for (int i = 0; i < 10; i++) begin
            pressed[3] = ~pressed[3];
            tick(2);
        end
        chk("bounce_no_valid", v_cyc.size(), 0);
        press_and_check(3, 6);

        // Ghost / multi-key on a row: rows keep rotating, nothing reported.
        for (int g = 0; g < 2; g++) begin
            if (g == 0) begin
                rr = 1; c1 = 0; c2 = 2;
            end else begin
                rr = $urandom_range(0, ROWS - 1);
                c1 = $urandom_range(0, COLS - 1);
                c2 = (c1 + $urandom_range(1, COLS - 1)) % COLS;
            end
            clear_log();
            pressed = '0;
            pressed[rr*COLS+c1] = 1'b1;
            pressed[rr*COLS+c2] = 1'b1;
            found = 1'b0;
            for (int i = 0; i < 20; i++) if (lin_matrix == 4'b1110) tick(1);
            for (int i = 0; i < 20; i++) begin
                if (!found) begin
                    if (lin_matrix == 4'b1110) found = 1'b1;
                    else tick(1);
                end
            end
            chk("ghost_sync", 32'(found), 1);
            for (int i = 0; i < 16; i++) begin
                exp_lin = ~(one_hot << ((i / SETTLE_CYCLES) % ROWS));
                chk("ghost_rotation", 32'(lin_matrix), 32'(exp_lin));
                tick(1);
            end
            chk("ghost_no_valid", v_cyc.size(), 0);
            chk("ghost_no_release", r_cyc.size(), 0);
        end
        pressed = '0;
        tick(4);

        // Second key on the same row while key 5 is held.
        clear_log();
        pressed[5] = 1'b1;
        wait_valid(300, got);
        chk("second_press_seen", 32'(got), 1);
        if (got) chk("second_press_code", 32'(v_code[0]), 5);
        tick(3);
        pressed[7] = 1'b1;
        tick(8);
        chk("second_no_new_valid", v_cyc.size(), 1);
        pressed[5] = 1'b0;
        pressed[7] = 1'b0;
        x = cyc;
        tick(DEBOUNCE + 3);
        chk("second_release_count", r_cyc.size(), 1);
        if (r_cyc.size() > 0) chk("second_release_cycle", r_cyc[0], x + DEBOUNCE);
        chk("second_held_off", 32'(key_held), 0);
        chk("second_valid_total", v_cyc.size(), 1);

        // Random presses at random scan phases and hold lengths.
        for (int n = 0; n < 4; n++) begin
            tick($urandom_range(0, 7));
            press_and_check($urandom_range(0, ROWS*COLS - 1), $urandom_range(1, 45));
        end

        // Reset while a key is held: outputs drop at once, no release pulse.
        clear_log();
        pressed[10] = 1'b1;
        wait_valid(300, got);
        chk("rst_hold_press_seen", 32'(got), 1);
        tick(2);
        reset = 1'b0;
        #1;
        chk("rst_hold_held", 32'(key_held), 0);
        chk("rst_hold_lin", 32'(lin_matrix), 32'hF);
        chk("rst_hold_valid", 32'(key_valid), 0);
        chk("rst_hold_code", 32'(key_code), 0);
        tick(2);
        pressed[10] = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(20);
        chk("rst_hold_no_release", r_cyc.size(), 0);
        chk("rst_hold_valid_total", v_cyc.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner_param.md
Name: keypad_scanner_param

Overview:
- Parametrised successor to the fixed 4x4 keypad decoder.
- Scans a ROWS x COLS matrix keypad and debounces presses and releases.
- Rejects multi-key and ghost presses; optional auto-repeat.
- Emits a linear key index (row*COLS+col) to the lock controller's input path; key-to-digit mapping is done downstream.

Parameters:
- ROWS, 4: number of driven row lines (2..16).
- COLS, 4: number of sensed column lines (2..16).
- SETTLE_CYCLES, 2: cycles a row is driven before its columns are sampled (>=1).
- DEBOUNCE_CYCLES, 25: consecutive stable cycles required to accept a press or a release (>=1).
- REPEAT_EN, 0: 1 enables auto-repeat.
- REPEAT_DELAY, 500000: cycles held after acceptance before the first repeat.
- REPEAT_PERIOD, 100000: cycles between subsequent repeats.
- Derived: KW = $clog2(ROWS*COLS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- scan_en  in  1  1 = scanning enabled.
- col_matrix  in  COLS  column sense, active-low (0 = key closed on the driven row); already synchronised upstream.
- lin_matrix  out  ROWS  row drive, active-low one-hot, or all-ones.
- key_code  out  KW  index of the accepted key; holds its value until the next key_valid.
- key_valid  out  1  one-cycle pulse per accepted press or repeat.
- key_repeat  out  1  qualifies key_valid: 1 = auto-repeat event; 0 otherwise.
- key_held  out  1  level; 1 from the press pulse until the release pulse.
- key_release  out  1  one-cycle pulse when the held key is accepted as released.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, row=0, all counters 0.
  - lin_matrix all ones; key_code=0; key_valid, key_repeat, key_held, key_release all 0.
- States: IDLE, SETTLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - lin_matrix all ones.
  - If scan_en=1, go to SETTLE with the current row.
- SETTLE:
  - Drive the current row low; count SETTLE_CYCLES.
  - In the final cycle, sample col_matrix:
    - exactly one bit 0: latch row/col, go to DEBOUNCE (count=1);
    - all ones: row = (row==ROWS-1) ? 0 : row+1, re-enter SETTLE;
    - two or more bits 0: multi-key; advance row as for all-ones; no output.
- DEBOUNCE:
  - Row held. Each cycle col_matrix must equal the latched pattern, else the count clears and the FSM returns to SETTLE on the next row.
  - When count reaches DEBOUNCE_CYCLES:
    - key_valid=1 for one cycle; key_repeat=0; key_code = row*COLS+col;
    - key_held=1; go to HELD.
  - Latency: key_valid asserts DEBOUNCE_CYCLES cycles after the SETTLE sample cycle.
- HELD:
  - Row held. Any bit low, latched or extra, keeps HELD; no second key is reported while one is held.
  - All ones: go to RELEASE (count=1).
  - With REPEAT_EN=1, a hold counter runs while in HELD:
    - at REPEAT_DELAY, pulse key_valid with key_repeat=1 and the same key_code;
    - thereafter every REPEAT_PERIOD cycles.
  - The hold counter is not cleared by a RELEASE bounce that returns to HELD.
- RELEASE:
  - col_matrix all ones for DEBOUNCE_CYCLES consecutive cycles: key_release=1 for one cycle, key_held=0, advance row, go to SETTLE.
  - Any low bit before that: return to HELD (bounce).
- scan_en=0:
  - From SETTLE or DEBOUNCE: go to IDLE next cycle.
  - From HELD or RELEASE: finish the release (key_release is still emitted), then IDLE.
- Pulse exclusivity:
  - key_valid and key_release never assert in the same cycle.
  - key_repeat=0 whenever key_valid=0.
- Counter widths: sized by $clog2 of the largest compare value + 1; no wrap during a count.
- Reset mid-operation: all outputs return to reset values immediately; no release pulse is emitted.

Test Plan:
- Setup: ROWS=4, COLS=4, SETTLE_CYCLES=2, DEBOUNCE_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Clean press: key at row 2, col 1 closed for 60 cycles.
  - key_valid pulses once with key_code=9, key_repeat=0, 4 cycles after the row-2 sample.
  - key_held=1.
  - Repeats with key_code=9, key_repeat=1 at hold cycles 20, 28, 36, ...
  - key_release pulses 4 cycles after opening.
- Bouncing press: row 0, col 3 toggles every 2 cycles for 20 cycles, then stable.
  - No key_valid during bouncing.
  - Exactly one key_valid with key_code=3 after 4 stable cycles.
- Ghost/multi-key: row 1, cols 0 and 2 both low.
  - No key_valid; lin_matrix keeps rotating 1110, 1101, 1011, 0111, 1110.
- Second key while held: hold key 5 (row 1, col 1), then also close row 1, col 3.
  - No new key_valid.
  - Releasing both gives one key_release.
- Control cases:
  - scan_en=0 idle: lin_matrix=1111, no events.
  - reset=0 during HELD: key_held=0 and lin_matrix=1111 at once; no key_release.
